// File: rtl/cnn_result_collector_if.sv
// ---------------------------------------------------------------------------
// cnn_result_collector_if
// Bundles the two traffic paths of the result collector:
//   - result stream from the accelerator output FIFO (validIn/dataIn/readyOut)
//   - RISC-V bus read port (addrIn/rdEnIn/rdDataOut/rdAckOut)
// Modports:
//   slave  : collector side (consumes results, serves reads)
//   master : upstream / bus side (produces results, issues reads)
// ---------------------------------------------------------------------------
interface cnn_result_collector_if #(
   parameter int DATA_WIDTH     = 32,
   parameter int BUS_ADDR_WIDTH = 32,
   parameter int BUS_DATA_WIDTH = 64
);
   logic                      validIn;
   logic [DATA_WIDTH-1:0]     dataIn;
   logic                      readyOut;
   logic [BUS_ADDR_WIDTH-1:0] addrIn;
   logic                      rdEnIn;
   logic [BUS_DATA_WIDTH-1:0] rdDataOut;
   logic                      rdAckOut;

   modport slave (
      input  validIn, dataIn, addrIn, rdEnIn,
      output readyOut, rdDataOut, rdAckOut
   );

   modport master (
      output validIn, dataIn, addrIn, rdEnIn,
      input  readyOut, rdDataOut, rdAckOut
   );
endinterface

// File: rtl/cnn_result_collector.sv
// ---------------------------------------------------------------------------
// cnn_result_collector
// Collects a run of N results from the accelerator, packs them two per bus
// word into a dual-port buffer and lets the CPU read the buffer over a
// one-cycle-latency bus read port.
// Ports:
//   clkIn, rstIn      : clock (rising edge), async active-low reset
//   startIn           : begin a run of numResultsIn results (clamped)
//   numResultsIn      : requested result count
//   countOut          : results accepted so far in this run
//   busyOut / doneOut : run in progress / run complete
//   bus (slave)       : result stream + bus read port
// ---------------------------------------------------------------------------
module cnn_result_collector #(
   parameter int BUS_ADDR_WIDTH = 32,
   parameter int BUS_DATA_WIDTH = 64,
   parameter int DATA_WIDTH     = 32,
   parameter int MAX_RESULTS    = 4096,
   localparam int CNT_WIDTH     = $clog2(MAX_RESULTS) + 1
) (
   input  logic                 clkIn,
   input  logic                 rstIn,
   input  logic                 startIn,
   input  logic [CNT_WIDTH-1:0] numResultsIn,
   output logic [CNT_WIDTH-1:0] countOut,
   output logic                 busyOut,
   output logic                 doneOut,
   cnn_result_collector_if.slave bus
);
   localparam int WORDS  = MAX_RESULTS / 2;
   localparam int WIDX_W = $clog2(WORDS);
   localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_RESULTS);

   typedef enum logic [1:0] {IDLE, COLLECT, FLUSH, DONE} state_t;

   state_t                    state_q, state_d;
   logic [CNT_WIDTH-1:0]      n_q, n_d;
   logic [CNT_WIDTH-1:0]      count_q, count_d;
   logic [DATA_WIDTH-1:0]     low_q, low_d;
   logic [BUS_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                      rd_ack_q, rd_ack_d;

   logic [BUS_DATA_WIDTH-1:0] mem [WORDS];
   logic                      mem_we;
   logic [WIDX_W-1:0]         mem_waddr;
   logic [BUS_DATA_WIDTH-1:0] mem_wdata;
   logic [WIDX_W-1:0]         rd_idx;

   logic                      ready, busy, done, transfer, last;
   logic [CNT_WIDTH-1:0]      n_clamped;
   logic                      unused_addr;

   assign n_clamped = (numResultsIn > MAX_CNT) ? MAX_CNT : numResultsIn;
   assign transfer  = bus.validIn & ready;
   assign last      = (count_q == n_q - CNT_WIDTH'(1));

   // Byte address -> word index; upper bits wrap, byte-in-word bits ignored.
   assign rd_idx      = bus.addrIn[WIDX_W+2:3];
   assign unused_addr = ^{bus.addrIn[BUS_ADDR_WIDTH-1:WIDX_W+3], bus.addrIn[2:0]};

   // ---------------- state register ----------------
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clkIn or negedge rstIn) begin
      if (!rstIn) begin
         state_q   <= IDLE;
         n_q       <= '0;
         count_q   <= '0;
         low_q     <= '0;
         rd_data_q <= '0;
         rd_ack_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         n_q       <= n_d;
         count_q   <= count_d;
         low_q     <= low_d;
         rd_data_q <= rd_data_d;
         rd_ack_q  <= rd_ack_d;
      end
   end

   // ---------------- next-state logic ----------------
   // NOTE: every variable gets a default at the top of the block so no path
   // leaves it unassigned, which would infer a latch.
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      count_d = count_q;
      low_d   = low_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (startIn) begin
               n_d     = n_clamped;
               count_d = '0;
               state_d = (n_clamped == '0) ? DONE : COLLECT;
            end
         end
         COLLECT: begin
            if (transfer) begin
               count_d = count_q + CNT_WIDTH'(1);
               // Even index parks in the low half until its partner arrives.
               if (!count_q[0]) low_d = bus.dataIn;
               if (last) state_d = n_q[0] ? FLUSH : DONE;
            end
         end
         FLUSH:   state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- output logic ----------------
   always_comb begin
      ready     = (state_q == COLLECT);
      busy      = (state_q == COLLECT) || (state_q == FLUSH);
      done      = (state_q == DONE);
      mem_we    = 1'b0;
      mem_waddr = count_q[WIDX_W:1];
      mem_wdata = {bus.dataIn, low_q};
      if (state_q == COLLECT && bus.validIn && count_q[0]) begin
         mem_we = 1'b1;
      end else if (state_q == FLUSH) begin
         // Odd run length: last result alone in the low half, upper half zero.
         // n_q is odd here, so n_q>>1 equals (n_q-1)>>1.
         mem_we    = 1'b1;
         mem_waddr = n_q[WIDX_W:1];
         mem_wdata = {{DATA_WIDTH{1'b0}}, low_q};
      end
   end

   // ---------------- result buffer ----------------
   // NOTE: the buffer has no reset; its contents survive rstIn and are only
   // meaningful once written, which keeps it mappable onto block RAM.
   always_ff @(posedge clkIn) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   // Read samples the array before this edge's write lands, so a same-cycle
   // read of the word being written returns its previous contents.
   always_comb begin
      rd_ack_d  = bus.rdEnIn;
      rd_data_d = bus.rdEnIn ? mem[rd_idx] : rd_data_q;
   end

   assign bus.readyOut  = ready;
   assign bus.rdDataOut = rd_data_q;
   assign bus.rdAckOut  = rd_ack_q;
   assign countOut      = count_q;
   assign busyOut       = busy;
   assign doneOut       = done;
endmodule

// File: doc/cnn_result_collector.md
CNN_RESULT_COLLECTOR -- requirements
Module: cnn_result_collector

Interface
REQ-001 SHALL have parameter BUS_ADDR_WIDTH, default 32, RISC-V bus address width.
REQ-002 SHALL have parameter BUS_DATA_WIDTH, default 64, bus read-data width (two results per word).
REQ-003 SHALL have parameter DATA_WIDTH, default 32, result width (single-precision float, opaque bits).
REQ-004 SHALL have parameter MAX_RESULTS, default 4096, buffer capacity in results (even, power of 2); CNT_WIDTH = $clog2(MAX_RESULTS)+1.
REQ-005 clkIn  input  1  sole clock, rising edge.
REQ-006 rstIn  input  1  reset, asynchronous assert, active-low.
REQ-007 startIn  input  1  begin collection run.
REQ-008 numResultsIn  input  CNT_WIDTH  results expected in the run.
REQ-009 validIn  input  1  upstream result valid (from accelerator output FIFO).
REQ-010 dataIn  input  DATA_WIDTH  upstream result.
REQ-011 readyOut  output  1  collector accepts a result this cycle.
REQ-012 addrIn  input  BUS_ADDR_WIDTH  bus byte address.
REQ-013 rdEnIn  input  1  bus read request.
REQ-014 rdDataOut  output  BUS_DATA_WIDTH  bus read data.
REQ-015 rdAckOut  output  1  read data valid.
REQ-016 countOut  output  CNT_WIDTH  results accepted in current run.
REQ-017 busyOut  output  1  run in progress (COLLECT or FLUSH).
REQ-018 doneOut  output  1  run complete, buffer holds all results.

Function
REQ-019 States SHALL be IDLE, COLLECT, FLUSH, DONE.
REQ-020 IDLE or DONE + startIn: latch N = min(numResultsIn, MAX_RESULTS), countOut<=0, go COLLECT; N==0 -> go DONE directly.
REQ-021 startIn in COLLECT or FLUSH SHALL be ignored.
REQ-022 readyOut SHALL be 1 exactly when state==COLLECT (combinational from state register); transfer = validIn & readyOut.
REQ-023 Each transfer: countOut += 1; result index k = countOut before increment.
REQ-024 Even k: dataIn held in a low-half register, no RAM write.
REQ-025 Odd k: RAM word k>>1 written {dataIn, low-half register} in the same cycle (result k-1 in bits [31:0], k in [63:32]).
REQ-026 Transfer of index N-1: N even -> DONE next cycle; N odd -> FLUSH next cycle.
REQ-027 FLUSH: write word (N-1)>>1 = {32'b0, low-half register}, go DONE next cycle (one cycle in FLUSH).
REQ-028 DONE: doneOut=1, busyOut=0, readyOut=0; remain until startIn.
REQ-029 busyOut=1 in COLLECT and FLUSH only; doneOut=1 in DONE only.
REQ-030 Buffer SHALL be MAX_RESULTS/2 words x BUS_DATA_WIDTH, separate write port (collector) and read port (bus).
REQ-031 Bus read: word index = addrIn[$clog2(MAX_RESULTS/2)+2:3]; upper bits ignored (wrap); bits [2:0] ignored.
REQ-032 rdEnIn at cycle t -> rdDataOut and rdAckOut=1 at t+1; rdAckOut=0 otherwise; rdDataOut holds last value when no read.
REQ-033 Reads SHALL be served in every state, one per cycle, back-to-back.
REQ-034 Same-cycle read and write of same word SHALL return pre-write contents.
REQ-035 Words not written in the current run SHALL return prior contents (buffer not cleared).

Reset
REQ-036 rstIn low SHALL immediately force state IDLE, readyOut=0, rdAckOut=0, rdDataOut=0, countOut=0, busyOut=0, doneOut=0, low-half register=0.
REQ-037 Reset mid-run SHALL abandon the run; RAM contents unspecified-preserved; collection resumes only on new startIn after rstIn high.

Verification
REQ-038 N=4, results 0x3F800000,0x40000000,0x40400000,0x40800000 back-to-back -> doneOut 1 cycle after 4th transfer; read addr 0x0 -> 0x40000000_3F800000, addr 0x8 -> 0x40800000_40400000, each rdAckOut one cycle later.
REQ-039 N=3, results A,B,C with validIn gaps -> FLUSH one cycle, DONE next; addr 0x8 -> 0x00000000_C; countOut=3.
REQ-040 N=0 start -> doneOut=1 next cycle, readyOut never asserted.
REQ-041 numResultsIn=MAX_RESULTS+5 -> exactly MAX_RESULTS transfers accepted, then readyOut=0, doneOut=1; addr MAX_RESULTS*4 wraps to word 0.
REQ-042 rstIn low after 2 of N=6 transfers -> all outputs zero asynchronously; new start with N=2 completes normally.
REQ-043 Read of word 1 in same cycle as its write during N=4 run -> old contents; read next cycle -> new contents.
